// File: rtl/pe_bus_arb_if.sv
// Requester/bus bundle for pe_bus_arb: per-PE request/address/completion plus the
// single shared bus transaction port.
interface pe_bus_arb_if #(
  parameter int N_PE      = 4,
  parameter int AD_LEN    = 32,
  parameter int BUS_WIDTH = 32
);
  logic [N_PE-1:0]        req_i;
  logic [N_PE*AD_LEN-1:0] ad_i;
  logic [N_PE-1:0]        valid_o;
  logic                   err_o;
  logic [BUS_WIDTH-1:0]   data_o;
  logic [N_PE-1:0]        stall_o;
  logic                   bus_req_o;
  logic [AD_LEN-1:0]      bus_ad_o;
  logic [BUS_WIDTH-1:0]   bus_data_i;
  logic                   bus_ack_i;

  // Arbiter side
  modport slave (
    input  req_i, ad_i, bus_data_i, bus_ack_i,
    output valid_o, err_o, data_o, stall_o, bus_req_o, bus_ad_o
  );

  // PE cluster / bus model side
  modport master (
    output req_i, ad_i, bus_data_i, bus_ack_i,
    input  valid_o, err_o, data_o, stall_o, bus_req_o, bus_ad_o
  );
endinterface

// File: rtl/pe_bus_arb.sv
// Round-robin arbiter serialising N_PE requesters onto one bus port, returning read
// data to the owner with a one-cycle valid pulse; a watchdog aborts hung transfers.
module pe_bus_arb #(
  parameter int N_PE      = 4,
  parameter int AD_LEN    = 32,
  parameter int BUS_WIDTH = 32,
  parameter int TIMEOUT   = 64
) (
  input  logic          clk_i,
  input  logic          reset_i,
  pe_bus_arb_if.slave   bus
);

  localparam int OW    = $clog2(N_PE);
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [OW-1:0]    LAST_RST = OW'(N_PE - 1);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t               state_q, state_d;
  logic [OW-1:0]        owner_q, owner_d;
  logic [OW-1:0]        last_q, last_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [AD_LEN-1:0]    ad_q, ad_d;
  logic [BUS_WIDTH-1:0] data_q, data_d;
  logic [N_PE-1:0]      valid_q, valid_d;
  logic                 err_q, err_d;
  logic                 bus_req_q, bus_req_d;

  logic [OW-1:0]        pick;
  logic [AD_LEN-1:0]    ad_sel;

  // First requesting channel strictly after 'last', wrapping modulo N_PE.
  function automatic logic [OW-1:0] rr_pick(input logic [N_PE-1:0] req,
                                            input logic [OW-1:0]   last);
    logic [OW-1:0] sel;
    logic [OW-1:0] idx;
    logic          found;
    sel   = '0;
    found = 1'b0;
    for (int k = 1; k <= N_PE; k++) begin
      idx = OW'((int'(last) + k) % N_PE);
      if (!found && req[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  always_comb begin
    pick   = rr_pick(bus.req_i, last_q);
    ad_sel = '0;
    for (int c = 0; c < N_PE; c++) begin
      if (pick == OW'(c)) ad_sel = bus.ad_i[c*AD_LEN +: AD_LEN];
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      last_q    <= LAST_RST;
      cnt_q     <= '0;
      ad_q      <= '0;
      data_q    <= '0;
      valid_q   <= '0;
      err_q     <= 1'b0;
      bus_req_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      ad_q      <= ad_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      bus_req_q <= bus_req_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    ad_d      = ad_q;
    data_d    = data_q;
    valid_d   = '0;
    err_d     = 1'b0;
    bus_req_d = bus_req_q;

    case (state_q)
      IDLE: begin
        // bus_ack_i is deliberately ignored here: no transaction is outstanding.
        if (|bus.req_i) begin
          owner_d   = pick;
          ad_d      = ad_sel;
          bus_req_d = 1'b1;
          cnt_d     = '0;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        if (bus.bus_ack_i) begin
          data_d    = bus.bus_data_i;
          for (int c = 0; c < N_PE; c++) valid_d[c] = (owner_q == OW'(c));
          bus_req_d = 1'b0;
          last_d    = owner_q;
          state_d   = IDLE;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          // Ack has priority above; reaching here means the bus never answered.
          data_d    = '1;
          for (int c = 0; c < N_PE; c++) valid_d[c] = (owner_q == OW'(c));
          err_d     = 1'b1;
          bus_req_d = 1'b0;
          last_d    = owner_q;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  assign bus.valid_o   = valid_q;
  assign bus.err_o     = err_q;
  assign bus.data_o    = data_q;
  assign bus.bus_req_o = bus_req_q;
  assign bus.bus_ad_o  = ad_q;
  assign bus.stall_o   = bus.req_i & ~valid_q;

endmodule

// File: tb/tb_pe_bus_arb.sv
// Bench for pe_bus_arb: directed scenarios plus random traffic, all cycles compared
// against a transaction-level reference model of the arbiter.
module tb_pe_bus_arb;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pe_bus_arb_if #(.N_PE(N), .AD_LEN(AW), .BUS_WIDTH(DW)) bif ();

  pe_bus_arb #(.N_PE(N), .AD_LEN(AW), .BUS_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bif)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // Requester and bus-responder stimulus state
  logic [N-1:0]  req = '0;
  logic [N-1:0]  keep = '0;
  logic [AW-1:0] addr [N];
  logic          ack = 1'b0;
  logic [DW-1:0] bdata = '0;
  logic [DW-1:0] ack_data = '0;
  int            ack_delay = 0;
  int            wait_cnt = 0;
  bit            rand_mode = 0;

  // Reference model: one transaction in flight with its owner and age
  bit            m_busy = 0;
  int            m_owner = 0;
  int            m_last = N - 1;
  int            m_age = 0;
  logic [AW-1:0] m_addr = '0;
  logic [N-1:0]  m_valid = '0;
  bit            m_err = 0;
  logic [DW-1:0] m_data = '0;

  int obs[$];

  task automatic apply();
    bif.req_i = req;
    for (int c = 0; c < N; c++) bif.ad_i[c*AW +: AW] = addr[c];
    bif.bus_ack_i  = ack;
    bif.bus_data_i = bdata;
  endtask

  task automatic step();
    logic [N-1:0]  r;
    logic [AW-1:0] a [N];
    logic          k;
    logic [DW-1:0] d;
    bit            found;
    @(negedge clk);
    for (int c = 0; c < N; c++) begin
      if (bif.valid_o[c]) begin
        req[c]  = keep[c] | (rand_mode && ($urandom_range(1) == 1));
        addr[c] = $urandom;
      end else if (rand_mode && !req[c] && ($urandom_range(3) == 0)) begin
        req[c]  = 1'b1;
        addr[c] = $urandom;
      end
    end
    if (bif.bus_req_o) begin
      if (rand_mode && wait_cnt == 0) ack_delay = $urandom_range(0, 10);
      ack   = (ack_delay >= 0) && (wait_cnt == ack_delay);
      bdata = rand_mode ? DW'($urandom) : ack_data;
      wait_cnt++;
    end else begin
      wait_cnt = 0;
      ack      = rand_mode && ($urandom_range(3) == 0);
      bdata    = $urandom;
    end
    apply();
    r = req; a = addr; k = ack; d = bdata;
    @(posedge clk);
    m_valid = '0;
    m_err   = 0;
    if (rst) begin
      m_busy = 0;
      m_last = N - 1;
    end else if (m_busy) begin
      m_age++;
      if (k) begin
        m_valid[m_owner] = 1'b1; m_data = d; m_busy = 0; m_last = m_owner;
      end else if (m_age == TO) begin
        m_valid[m_owner] = 1'b1; m_err = 1; m_data = '1; m_busy = 0; m_last = m_owner;
      end
    end else if (r != '0) begin
      found = 0;
      for (int j = 1; j <= N; j++) begin
        if (!found && r[(m_last + j) % N]) begin
          m_owner = (m_last + j) % N;
          found   = 1;
        end
      end
      m_busy = 1; m_age = 0; m_addr = a[m_owner];
    end
    #1;
    chk("bus_req", bif.bus_req_o, m_busy);
    chk("valid", bif.valid_o, m_valid);
    chk("err", bif.err_o, m_err);
    chk("stall", bif.stall_o, r & ~m_valid);
    if (m_valid != '0) chk("data", bif.data_o, m_data);
    if (m_busy) chk("bus_ad", bif.bus_ad_o, m_addr);
    for (int c = 0; c < N; c++) if (bif.valid_o[c]) obs.push_back(c);
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; keep = '0; rand_mode = 0; ack_delay = 0;
    repeat (2) step();
    rst = 1'b0;
    obs.delete();
  endtask

  task automatic run_to_valid(input string tag, input int budget, output int hi);
    bit seen;
    seen = 0; hi = 0;
    for (int b = 0; b < budget && !seen; b++) begin
      step();
      if (bif.bus_req_o) hi++;
      if (bif.valid_o != '0) seen = 1;
    end
    chk(tag, seen, 1);
  endtask

  task automatic wait_obs(input string tag, input int n, input int budget);
    for (int b = 0; b < budget && obs.size() < n; b++) step();
    chk(tag, obs.size(), n);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    int hi;
    int lastpos [N];
    int gap;
    for (int c = 0; c < N; c++) addr[c] = '0;
    req = 4'b1010;
    apply();
    rst = 1'b1;
    #1;
    chk("rst_bus_req", bif.bus_req_o, 0);
    chk("rst_bus_ad", bif.bus_ad_o, 0);
    chk("rst_data", bif.data_o, 0);
    chk("rst_valid", bif.valid_o, 0);
    chk("rst_err", bif.err_o, 0);
    chk("rst_stall", bif.stall_o, 4'b1010);
    do_reset();

    // Single request on ch2
    ack_delay = 0; ack_data = 32'hDEADBEEF;
    req[2] = 1'b1; addr[2] = 32'h100;
    step();
    chk("t1_bus_ad", bif.bus_ad_o, 32'h100);
    chk("t1_stall_hi", bif.stall_o[2], 1);
    step();
    chk("t1_valid", bif.valid_o, 4'b0100);
    chk("t1_data", bif.data_o, 32'hDEADBEEF);
    chk("t1_err", bif.err_o, 0);
    step();
    chk("t1_stall_lo", bif.stall_o[2], 0);

    // Simultaneous requests from reset
    do_reset();
    ack_delay = 0;
    req = 4'b1011;
    repeat (12) step();
    chk("t2_count", obs.size(), 3);
    if (obs.size() == 3) begin
      chk("t2_g0", obs[0], 0);
      chk("t2_g1", obs[1], 1);
      chk("t2_g2", obs[2], 3);
    end

    // Saturation
    do_reset();
    ack_delay = 0; keep = 4'b1111; req = 4'b1111;
    wait_obs("t3_done", 12, 100);
    for (int c = 0; c < N; c++) lastpos[c] = -1;
    for (int i = 0; i < obs.size(); i++) begin
      chk("t3_order", obs[i], i % N);
      gap = (lastpos[obs[i]] < 0) ? i + 1 : i - lastpos[obs[i]];
      chk("t3_wait_le4", gap <= N, 1);
      lastpos[obs[i]] = i;
    end
    keep = '0;

    // Timeout on ch1
    do_reset();
    ack_delay = -1;
    req[1] = 1'b1;
    run_to_valid("t4_seen", 20, hi);
    chk("t4_busy_cycles", hi, TO);
    chk("t4_valid", bif.valid_o, 4'b0010);
    chk("t4_err", bif.err_o, 1);
    chk("t4_data", bif.data_o, 32'hFFFFFFFF);
    step();
    chk("t4_idle", bif.bus_req_o, 0);

    // Ack on the last busy cycle beats the watchdog
    do_reset();
    ack_delay = TO - 1; ack_data = 32'h1234;
    req[1] = 1'b1;
    run_to_valid("t5_seen", 20, hi);
    chk("t5_busy_cycles", hi, TO);
    chk("t5_valid", bif.valid_o, 4'b0010);
    chk("t5_err", bif.err_o, 0);
    chk("t5_data", bif.data_o, 32'h1234);

    // Reset mid-transaction
    do_reset();
    ack_delay = 0;
    req[1] = 1'b1;
    run_to_valid("t6_pre", 10, hi);
    ack_delay = -1;
    req[3] = 1'b1;
    step(); step();
    chk("t6_busy", bif.bus_req_o, 1);
    rst = 1'b1;
    #1;
    chk("t6_async_drop", bif.bus_req_o, 0);
    req[0] = 1'b1;
    step(); step();
    rst = 1'b0;
    obs.delete();
    ack_delay = 0;
    wait_obs("t6_done", 2, 20);
    if (obs.size() == 2) begin
      chk("t6_first", obs[0], 0);
      chk("t6_second", obs[1], 3);
    end

    // Random traffic
    do_reset();
    rand_mode = 1;
    repeat (800) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pe_bus_arb.md
# pe_bus_arb

Round-robin bus arbiter for clusters of processing elements that share one instruction/data bus. It accepts up to N_PE address requests, serialises them onto a single bus transaction port with a request/acknowledge handshake, and returns the read data to the owning requester. Requesters see a per-channel stall. A watchdog terminates hung transactions with an error flag. It sits between the per-PE fetch units and the external bus.

## Interface
Parameters:
- N_PE, 4, number of requester channels (≥2)
- AD_LEN, 32, bus address width
- BUS_WIDTH, 32, bus data width
- TIMEOUT, 64, maximum bus-busy cycles before forced termination; 0 disables the watchdog

Ports:
- clk_i  input  1  clock; all state updates on its rising edge
- reset_i  input  1  reset, asynchronous, active-high
- req_i  input  N_PE  per-channel request; bit i belongs to channel i
- ad_i  input  N_PE*AD_LEN  per-channel address; channel i at bits [i*AD_LEN +: AD_LEN]
- valid_o  output  N_PE  one-cycle completion pulse, at most one bit set
- err_o  output  1  qualifies the current valid_o pulse as a timeout termination
- data_o  output  BUS_WIDTH  returned data, shared by all channels, meaningful only while valid_o is nonzero
- stall_o  output  N_PE  channel i has a pending request that is not completing this cycle
- bus_req_o  output  1  bus transaction in progress
- bus_ad_o  output  AD_LEN  transaction address, stable while bus_req_o=1
- bus_data_i  input  BUS_WIDTH  bus read data, sampled with bus_ack_i
- bus_ack_i  input  1  bus completes the transaction this cycle

## Operation
- States: IDLE and BUSY. Registers: owner (index width $clog2(N_PE)), last_grant, watchdog counter (width $clog2(TIMEOUT+1)).
- IDLE: if any req_i bit is set, grant the first set bit searching from last_grant+1 upward, modulo N_PE. Latch ad_i of the winner into bus_ad_o, set owner, assert bus_req_o, clear the counter, and go to BUSY. With no requests, stay in IDLE.
- BUSY, bus_ack_i=1: latch bus_data_i into data_o, pulse valid_o[owner], set err_o=0, drop bus_req_o, set last_grant=owner, and go to IDLE.
- BUSY, no ack, TIMEOUT≠0, counter reaches TIMEOUT-1: terminate the transaction. data_o gets all ones, valid_o[owner] and err_o pulse, bus_req_o drops, last_grant=owner, and the state goes to IDLE. Otherwise the counter increments.
- Ack wins over timeout in the same cycle, so err_o stays 0.
- An ack seen in IDLE is ignored.
- stall_o[i] = req_i[i] & ~valid_o[i] (combinational).
- Requester rules:
  - Hold req_i and ad_i stable until valid_o[i] is seen.
  - ad_i is sampled only at grant.
  - If req_i[i] is still high in the valid cycle, that is a new request.
- Non-owning channels' requests are never dropped; they wait.
- Fairness: each pending channel is granted within N_PE transactions.

## Timing
- Reset values: bus_req_o=0, bus_ad_o=0, data_o=0, valid_o=0, err_o=0, state=IDLE, last_grant=N_PE-1 (channel 0 is first priority).
- stall_o follows req_i during reset.
- Reset mid-transaction: bus_req_o drops asynchronously, the transaction is abandoned, and no valid_o pulse is generated.
- Request seen in IDLE at edge N → bus_req_o and bus_ad_o valid after edge N.
- bus_ack_i sampled high at edge M (M≥N+1) → valid_o/data_o after edge M for one cycle. The arbiter is in IDLE in that cycle and may grant again at edge M+1.
- Minimum request-to-valid latency is 2 cycles. Back-to-back throughput is one transaction per (1 + ack latency) cycles.
- Watchdog: with no ack, termination occurs TIMEOUT cycles after bus_req_o rises.
- All outputs except stall_o are registered.

## Test plan
- Single request: ch2 requests ad=0x100, ack 1 cycle later with data 0xDEADBEEF.
  - Required: bus_ad_o=0x100 one cycle after the request, then valid_o=4'b0100, data_o=0xDEADBEEF, err_o=0.
  - Required: stall_o[2] high until the valid cycle.
- Simultaneous requests from reset: ch0, ch1 and ch3 request together and hold, each acked immediately.
  - Required: grant order 0, 1, 3.
  - Required: exactly three valid pulses and no duplicates.
- Saturation: all 4 channels request continuously for 12 transactions.
  - Required: grant sequence 0,1,2,3,0,1,2,3,0,1,2,3.
  - Required: no channel waits more than 4 grants.
- Timeout: TIMEOUT=8, ch1 requests, ack never arrives.
  - Required: bus_req_o high exactly 8 cycles.
  - Required: then valid_o=4'b0010, err_o=1, data_o=0xFFFFFFFF, then IDLE.
- Ack-timeout collision: TIMEOUT=8, ack arrives on the 8th busy cycle with data 0x1234.
  - Required: valid_o=4'b0010, err_o=0, data_o=0x1234.
- Reset mid-transaction: assert reset_i during BUSY between clock edges.
  - Required: bus_req_o drops immediately and no valid_o pulse appears.
  - Required: after release, a pending ch3 request is granted normally and ch0 keeps first priority.
